// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the memory-stage controller: FSM encoding,
// write-back select codes, default widths and the branch-condition helper.
package mem_stage_ctrl_pkg;

    localparam int DEF_AWIDTH  = 32;
    localparam int DEF_DWIDTH  = 32;
    localparam int DEF_TIMEOUT = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // Write-back select codes carried through MEM/WB; a bubble reuses the ALU code.
    localparam logic [1:0] MEMTOREG_ALU    = 2'd0;
    localparam logic [1:0] MEMTOREG_MEM    = 2'd1;
    localparam logic [1:0] MEMTOREG_PC     = 2'd2;
    localparam logic [1:0] MEMTOREG_BUBBLE = MEMTOREG_ALU;

    function automatic logic branch_taken(
        input logic beq,
        input logic bne,
        input logic blez,
        input logic bgtz,
        input logic zero,
        input logic neg
    );
        return (beq & zero) | (bne & ~zero) | (blez & (zero | neg)) |
               (bgtz & ~zero & ~neg);
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_memwbreg.sv
// MEM/WB pipeline register: captures a completing instruction, or inserts a
// bubble (no register write) while the memory stage is stalled.
module memwbreg
    import mem_stage_ctrl_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              capture_i,
    input  logic              load_i,
    input  logic              abort_i,
    input  logic [1:0]        memtoreg_i,
    input  logic              regwr_i,
    input  logic [DWIDTH-1:0] aluout_i,
    input  logic [4:0]        regdst_i,
    input  logic [DWIDTH-1:0] rdata_i,
    output logic [1:0]        memtoreg_o,
    output logic              regwr_o,
    output logic [DWIDTH-1:0] aluout_o,
    output logic [DWIDTH-1:0] memdata_o,
    output logic [4:0]        regdst_o
);

    logic [1:0]        memtoreg_q, memtoreg_d;
    logic              regwr_q, regwr_d;
    logic [DWIDTH-1:0] aluout_q, aluout_d;
    logic [DWIDTH-1:0] memdata_q, memdata_d;
    logic [4:0]        regdst_q, regdst_d;

    always_comb begin
        memtoreg_d = memtoreg_q;
        regwr_d    = regwr_q;
        aluout_d   = aluout_q;
        memdata_d  = memdata_q;
        regdst_d   = regdst_q;
        if (capture_i) begin
            memtoreg_d = memtoreg_i;
            regwr_d    = regwr_i & ~abort_i;
            aluout_d   = aluout_i;
            regdst_d   = regdst_i;
            // Load data only moves on an acked read; an aborted access zeroes it.
            if (load_i) begin
                memdata_d = rdata_i;
            end else if (abort_i) begin
                memdata_d = '0;
            end
        end else begin
            memtoreg_d = MEMTOREG_BUBBLE;
            regwr_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memtoreg_q <= '0;
            regwr_q    <= 1'b0;
            aluout_q   <= '0;
            memdata_q  <= '0;
            regdst_q   <= '0;
        end else begin
            memtoreg_q <= memtoreg_d;
            regwr_q    <= regwr_d;
            aluout_q   <= aluout_d;
            memdata_q  <= memdata_d;
            regdst_q   <= regdst_d;
        end
    end

    assign memtoreg_o = memtoreg_q;
    assign regwr_o    = regwr_q;
    assign aluout_o   = aluout_q;
    assign memdata_o  = memdata_q;
    assign regdst_o   = regdst_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: dmem request/ack FSM with timeout abort, branch and
// jump resolution, and the MEM/WB register feeding write-back.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int AWIDTH  = DEF_AWIDTH,
    parameter int DWIDTH  = DEF_DWIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              memwrin,
    input  logic              memrdin,
    input  logic              bbnein,
    input  logic              bbeqin,
    input  logic              bblezin,
    input  logic              bbgtzin,
    input  logic              jumpin,
    input  logic [1:0]        memtoregin,
    input  logic              regwrin,
    input  logic [DWIDTH-1:0] aluoutin,
    input  logic              zeroin,
    input  logic              negativein,
    input  logic [4:0]        regdstmuxin,
    input  logic [DWIDTH-1:0] regdata2in,
    input  logic [AWIDTH-1:0] branaddrin,
    input  logic [AWIDTH-1:0] jmpaddrin,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [AWIDTH-1:0] dmem_addr,
    output logic [DWIDTH-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DWIDTH-1:0] dmem_rdata,
    output logic              mem_stall,
    output logic              pcsrc,
    output logic [AWIDTH-1:0] pctarget,
    output logic              dmem_err,
    output logic [1:0]        memtoregout,
    output logic              regwrout,
    output logic [DWIDTH-1:0] aluoutout,
    output logic [DWIDTH-1:0] memdataout,
    output logic [4:0]        regdstout,
    output logic              dbg_state_o
);

    localparam int              CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              stall;
    logic              wb_load;
    logic              wb_abort;
    logic              taken;

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        err_d    = err_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        stall    = 1'b0;
        wb_load  = 1'b0;
        wb_abort = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // dmem_ack is deliberately ignored here.
                if (memrdin | memwrin) begin
                    stall   = 1'b1;
                    addr_d  = aluoutin[AWIDTH-1:0];
                    wdata_d = regdata2in;
                    we_d    = memwrin;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (dmem_ack) begin
                    req_d   = 1'b0;
                    wb_load = ~we_q;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    req_d    = 1'b0;
                    err_d    = 1'b1;
                    wb_abort = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign taken = branch_taken(bbeqin, bbnein, bblezin, bbgtzin, zeroin, negativein);

    // A stalled instruction may only redirect in its completion cycle.
    assign pcsrc    = (jumpin | taken) & ~stall;
    assign pctarget = jumpin ? jmpaddrin : branaddrin;

    assign mem_stall   = stall;
    assign dmem_req    = req_q;
    assign dmem_we     = we_q;
    assign dmem_addr   = addr_q;
    assign dmem_wdata  = wdata_q;
    assign dmem_err    = err_q;
    assign dbg_state_o = state_q;

    memwbreg #(
        .DWIDTH(DWIDTH)
    ) u_memwb (
        .clk       (clk),
        .rst_n     (rst_n),
        .capture_i (~stall),
        .load_i    (wb_load),
        .abort_i   (wb_abort),
        .memtoreg_i(memtoregin),
        .regwr_i   (regwrin),
        .aluout_i  (aluoutin),
        .regdst_i  (regdstmuxin),
        .rdata_i   (dmem_rdata),
        .memtoreg_o(memtoregout),
        .regwr_o   (regwrout),
        .aluout_o  (aluoutout),
        .memdata_o (memdataout),
        .regdst_o  (regdstout)
    );

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory-stage controller: the consumer of the EX/MEM pipeline register outputs.
- Turns memrd/memwr into a data-memory request/acknowledge handshake, stalling the upstream pipeline while an access is outstanding.
- Resolves conditional branches and jumps, producing the PC redirect.
- Registers the MEM/WB stage outputs: write-back controls, ALU result, load data and destination register.

Parameters:
AWIDTH, 32, address width (branch/jump/dmem address)
DWIDTH, 32, data width
TIMEOUT, 16, max cycles waiting for dmem_ack before abort (>=2)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
memwrin  input  1  store request from EX/MEM
memrdin  input  1  load request from EX/MEM
bbnein, bbeqin, bblezin, bbgtzin  input  1 each  branch type flags
jumpin  input  1  jump flag
memtoregin  input  2  write-back select, passed through
regwrin  input  1  register write enable, passed through
aluoutin  input  DWIDTH  ALU result; also the data address
zeroin, negativein  input  1 each  ALU flags
regdstmuxin  input  5  destination register
regdata2in  input  DWIDTH  store data
branaddrin, jmpaddrin  input  AWIDTH  branch and jump targets
dmem_req  output  1  memory request, held until ack
dmem_we  output  1  1 = write
dmem_addr  output  AWIDTH  latched address
dmem_wdata  output  DWIDTH  latched store data
dmem_ack  input  1  memory acknowledge, 1-cycle pulse
dmem_rdata  input  DWIDTH  load data, valid with ack
mem_stall  output  1  freeze IF..EX/MEM (combinational)
pcsrc  output  1  redirect PC this cycle (combinational)
pctarget  output  AWIDTH  redirect target
dmem_err  output  1  sticky timeout error
memtoregout  output  2  MEM/WB write-back select
regwrout  output  1  MEM/WB register write enable
aluoutout  output  DWIDTH  MEM/WB ALU result
memdataout  output  DWIDTH  MEM/WB load data
regdstout  output  5  MEM/WB destination register

Behaviour:
- Reset (asynchronous, takes effect immediately): state=IDLE; dmem_req=0; dmem_we=0; dmem_addr=0; dmem_wdata=0; dmem_err=0; timeout counter=0; all MEM/WB outputs=0.
- FSM states: IDLE, WAIT.
- IDLE with (memrdin|memwrin):
  - Latch dmem_addr=aluoutin[AWIDTH-1:0], dmem_wdata=regdata2in, dmem_we=memwrin.
  - Assert dmem_req from the next cycle; go to WAIT.
  - mem_stall=1 in this cycle.
  - If memrdin and memwrin are both set, the write wins.
- WAIT:
  - dmem_req=1, counter increments each cycle.
  - mem_stall = !dmem_ack.
  - On ack: dmem_req drops the next cycle, state=IDLE, instruction completes this cycle.
  - Minimum load/store latency is 2 cycles (request cycle plus ack cycle).
- Timeout: if the counter reaches TIMEOUT-1 in WAIT without ack:
  - Abort: req drops, dmem_err is set (sticky until reset), state=IDLE.
  - The instruction completes with memdataout=0 and regwrout forced to 0.
- dmem_ack while IDLE is ignored. dmem_rdata is sampled only on the ack of a read.
- Completion cycle (mem_stall=0): at posedge, MEM/WB outputs capture memtoregin, regwrin, aluoutin, regdstmuxin.
  - memdataout captures dmem_rdata for an acked read; otherwise it holds its previous value.
- Stall cycle (mem_stall=1): MEM/WB captures a bubble (regwrout=0, memtoregout=0); other MEM/WB fields hold.
- EX/MEM inputs are held stable by upstream while mem_stall=1.
- Branch resolution:
  - taken = (bbeqin&zeroin) | (bbnein&~zeroin) | (bblezin&(zeroin|negativein)) | (bbgtzin&~zeroin&~negativein).
  - pcsrc = (jumpin|taken) & !mem_stall.
  - pctarget = jumpin ? jmpaddrin : branaddrin (jump has priority).
  - pcsrc is asserted exactly one cycle per instruction.
- Reset mid-access: req drops asynchronously, no write-back occurs, and a late ack after reset is ignored.

Decomposition:
- Shared package (e.g. mips_pkg):
  - state encoding (IDLE=0, WAIT=1)
  - memtoreg select constants
  - default AWIDTH/DWIDTH
- Sub-module: memwbreg, the MEM/WB pipeline register with capture/bubble control. Branch logic and the FSM stay in the top module.

Test Plan:
- Load, ack on 2nd WAIT cycle: aluoutin=0x100, rdata=0xDEADBEEF, regwrin=1, regdst=5.
  - dmem_req high for 2 cycles; mem_stall high 2 cycles then low.
  - Next cycle memdataout=0xDEADBEEF, regwrout=1, regdstout=5.
- Store: memwrin=1, aluoutin=0x40, regdata2in=0x1234, ack in the first WAIT cycle.
  - dmem_we=1, dmem_addr=0x40, dmem_wdata=0x1234; memdataout unchanged.
- Branches (no memop), each: pcsrc=1, pctarget=branaddrin for one cycle, no stall.
  - bbeqin=1, zeroin=1.
  - bblezin=1, negativein=1.
  - bbgtzin=1, zeroin=0, negativein=0.
- Branch not taken: bbnein=1, zeroin=1 -> pcsrc=0.
- Jump with bbeqin&zeroin also set: pctarget=jmpaddrin.
- Timeout: TIMEOUT=16, read, never ack.
  - req drops after 16 cycles in WAIT; dmem_err=1 and stays 1.
  - Write-back has regwrout=0, memdataout=0.
- rst_n low during WAIT: dmem_req=0 immediately.
  - A subsequent ack is ignored and all MEM/WB outputs stay 0 after release.
